// File: rtl/lbp_host.sv
// Host-side responder for the LBP engine: loads a gray image, serves engine reads,
// captures LBP writes and exposes results. Optional checker: LBP_HOST_BORDER_CHK_EN.
module lbp_host #(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [7:0]        gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              done,
    output logic [ADDR_W:0]   wr_cnt,
    output logic [31:0]       cyc_cnt,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              err
);

    localparam int               NPIX     = IMG_W * IMG_W;
    localparam logic [ADDR_W:0]  NPIX_W   = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [31:0]       cyc_cnt_q, cyc_cnt_d;
    logic [7:0]        gray_data_q, rd_data_q;

    logic [7:0] gray_mem [0:2**ADDR_W-1];
    logic [7:0] lbp_mem  [0:2**ADDR_W-1];

    logic load_fire, gray_rd_en, gray_in_range, lbp_in_range, lbp_wr_en;

    always_comb begin
        state_d       = state_q;
        ld_ptr_d      = ld_ptr_q;
        wr_cnt_d      = wr_cnt_q;
        cyc_cnt_d     = cyc_cnt_q;
        load_fire     = (state_q == ST_LOAD) && load_valid;
        gray_rd_en    = (state_q == ST_SERVE) && gray_req;
        gray_in_range = ({1'b0, gray_addr} < NPIX_W);
        lbp_in_range  = ({1'b0, lbp_addr} < NPIX_W);
        lbp_wr_en     = (state_q == ST_SERVE) && lbp_valid && lbp_in_range;
        case (state_q)
            ST_LOAD: begin
                if (load_fire) begin
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    if (ld_ptr_q == LAST_PTR) begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                if (cyc_cnt_q != 32'hFFFF_FFFF) begin
                    cyc_cnt_d = cyc_cnt_q + 32'd1;
                end
                if (lbp_wr_en) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            ld_ptr_q    <= '0;
            wr_cnt_q    <= '0;
            cyc_cnt_q   <= '0;
            gray_data_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q   <= state_d;
            ld_ptr_q  <= ld_ptr_d;
            wr_cnt_q  <= wr_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            if (gray_rd_en) begin
                gray_data_q <= gray_in_range ? gray_mem[gray_addr] : 8'h00;
            end
            // Read-before-write: a same-edge write becomes visible one cycle later.
            rd_data_q <= lbp_mem[rd_addr];
        end
    end

    // Memory arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            gray_mem[ld_ptr_q] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (lbp_wr_en) begin
            lbp_mem[lbp_addr] <= lbp_data;
        end
    end

`ifdef LBP_HOST_BORDER_CHK_EN
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_RC  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W:0]   INTERIOR = (ADDR_W + 1)'((IMG_W - 2) * (IMG_W - 2));

    logic              err_q, err_d;
    logic [ADDR_W-1:0] lbp_row, lbp_col;
    logic              on_border;

    always_comb begin
        lbp_row   = lbp_addr / IMG_W_A;
        lbp_col   = lbp_addr % IMG_W_A;
        on_border = (lbp_row == '0) || (lbp_row == LAST_RC) ||
                    (lbp_col == '0) || (lbp_col == LAST_RC);
        err_d     = err_q;
        if (state_q == ST_SERVE) begin
            if (lbp_valid && (!lbp_in_range || on_border)) begin
                err_d = 1'b1;
            end
            // Count includes a write landing in the same cycle as finish.
            if (finish && (wr_cnt_d != INTERIOR)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign load_ready = (state_q == ST_LOAD);
    assign gray_ready = (state_q == ST_SERVE);
    assign done       = (state_q == ST_DONE);
    assign gray_data  = gray_data_q;
    assign rd_data    = rd_data_q;
    assign wr_cnt     = wr_cnt_q;
    assign cyc_cnt    = cyc_cnt_q;

endmodule
